axis_demux_pkt: RTL and testbench

- Parametrised AXI-Stream 1:N packet demultiplexer; successor to the fixed 16-way broadcast-valid demux in the PCP datapath.
- Routes each whole packet to one master port, selected by a binary index sampled at packet start and held until tlast.
- Only the selected port sees tvalid. One registered output stage with skid gives full throughput inside a packet.
- Out-of-range indices drop the packet and count it.

---
 rtl/axis_demux_pkt.sv | 122 ++++++++++++
 tb/tb_axis_demux_pkt.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_demux_pkt.sv
// AXI-Stream 1:N packet demultiplexer: whole packets are steered to the port picked
// by sel_idx at packet start; out-of-range indices are swallowed and counted.
module axis_demux_pkt #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned N_OUT  = 16,
  parameter int unsigned SEL_W  = $clog2(N_OUT),
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic [DATA_W/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [N_OUT-1:0]      m_axis_tvalid,
  input  logic [N_OUT-1:0]      m_axis_tready,
  input  logic [SEL_W-1:0]      sel_idx,
  output logic                  busy,
  output logic [SEL_W-1:0]      cur_port,
  output logic [CNT_W-1:0]      drop_cnt
);

  localparam int unsigned KEEP_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

  state_t              state, state_nxt;
  logic                main_valid, skid_valid;
  logic [DATA_W-1:0]   skid_data;
  logic [KEEP_W-1:0]   skid_keep;
  logic                skid_last;
  logic                in_range, start, accept, route_acc, xfer;

  assign in_range  = 32'(sel_idx) < N_OUT;
  assign start     = (state == IDLE) && s_axis_tvalid && !main_valid && !skid_valid;
  assign accept    = s_axis_tvalid && s_axis_tready;
  assign route_acc = accept && (state == ROUTE);
  assign xfer      = |(m_axis_tvalid & m_axis_tready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = in_range ? ROUTE : DROP;
      ROUTE:   if (accept && s_axis_tlast) state_nxt = IDLE;
      DROP:    if (accept && s_axis_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = ((state == ROUTE) && !skid_valid) || (state == DROP);
    busy          = (state != IDLE) || main_valid || skid_valid;
  end

  always_comb begin
    m_axis_tvalid = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      m_axis_tvalid[i] = main_valid && (cur_port == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_port     <= '0;
      drop_cnt     <= '0;
      main_valid   <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tlast <= 1'b0;
      skid_valid   <= 1'b0;
      skid_data    <= '0;
      skid_keep    <= '0;
      skid_last    <= 1'b0;
    end else begin
      if (start) cur_port <= sel_idx;
      if ((state == DROP) && accept && s_axis_tlast && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
      // Skid only fills when main is stalled; ready is withheld while it is full,
      // so an accept and a full skid never coincide.
      if (xfer) begin
        if (skid_valid) begin
          m_axis_tdata <= skid_data;
          m_axis_tkeep <= skid_keep;
          m_axis_tlast <= skid_last;
          skid_valid   <= 1'b0;
        end else if (route_acc) begin
          m_axis_tdata <= s_axis_tdata;
          m_axis_tkeep <= s_axis_tkeep;
          m_axis_tlast <= s_axis_tlast;
        end else begin
          main_valid   <= 1'b0;
        end
      end else if (route_acc) begin
        if (main_valid) begin
          skid_data    <= s_axis_tdata;
          skid_keep    <= s_axis_tkeep;
          skid_last    <= s_axis_tlast;
          skid_valid   <= 1'b1;
        end else begin
          m_axis_tdata <= s_axis_tdata;
          m_axis_tkeep <= s_axis_tkeep;
          m_axis_tlast <= s_axis_tlast;
          main_valid   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_demux_pkt.sv
// Directed bench for axis_demux_pkt: a 16-port instance for routing scenarios and a
// 12-port instance with a 2-bit counter for drop and saturation scenarios.
`timescale 1ns/1ps
module tb_axis_demux_pkt;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] s_tdata, m_tdata;
  logic [3:0]  s_tkeep, m_tkeep;
  logic        s_tlast, s_tvalid, s_tready, m_tlast, busy;
  logic [15:0] m_tvalid, m_tready, drop_cnt;
  logic [3:0]  sel, cur_port;

  logic [31:0] b_s_tdata, b_m_tdata;
  logic [3:0]  b_s_tkeep, b_m_tkeep;
  logic        b_s_tlast, b_s_tvalid, b_s_tready, b_m_tlast, b_busy;
  logic [11:0] b_m_tvalid, b_m_tready;
  logic [3:0]  b_sel, b_cur_port;
  logic [1:0]  b_drop_cnt;

  axis_demux_pkt #(.DATA_W(32), .N_OUT(16), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .sel_idx(sel), .busy(busy), .cur_port(cur_port), .drop_cnt(drop_cnt)
  );

  axis_demux_pkt #(.DATA_W(32), .N_OUT(12), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(b_s_tdata), .s_axis_tkeep(b_s_tkeep), .s_axis_tlast(b_s_tlast),
    .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
    .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tlast(b_m_tlast),
    .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
    .sel_idx(b_sel), .busy(b_busy), .cur_port(b_cur_port), .drop_cnt(b_drop_cnt)
  );

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready: got %b expected 0", s_tready); end
    checks++; if (m_tvalid !== 16'h0) begin errors++; $display("FAIL reset_m_tvalid: got %h expected 0000", m_tvalid); end
    checks++; if (m_tdata !== 32'h0 || m_tkeep !== 4'h0 || m_tlast !== 1'b0) begin
      errors++; $display("FAIL reset_m_payload: got %h/%h/%b expected 0/0/0", m_tdata, m_tkeep, m_tlast); end
    checks++; if (busy !== 1'b0 || cur_port !== 4'd0 || drop_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_status: got busy=%b port=%0d cnt=%0d expected 0/0/0", busy, cur_port, drop_cnt); end
    checks++; if (b_m_tvalid !== 12'h0 || b_s_tready !== 1'b0 || b_drop_cnt !== 2'd0) begin
      errors++; $display("FAIL reset_b: got v=%h r=%b cnt=%0d expected 0/0/0", b_m_tvalid, b_s_tready, b_drop_cnt); end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] exp_keep;
    @(posedge clk); #1;
    m_tready = '1; sel = 4'd5; s_tvalid = 1'b1; s_tdata = 32'd1; s_tkeep = 4'hF; s_tlast = 1'b0;
    @(negedge clk);
    checks++; if (s_tready !== 1'b0 || m_tvalid !== 16'h0) begin
      errors++; $display("FAIL single_bubble: got ready=%b valid=%h expected 0/0000", s_tready, m_tvalid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (s_tready !== 1'b1 || m_tvalid !== 16'h0 || cur_port !== 4'd5) begin
      errors++; $display("FAIL single_route: got ready=%b valid=%h port=%0d expected 1/0000/5", s_tready, m_tvalid, cur_port); end
    for (int unsigned k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k < 4) begin
        s_tdata = 32'(k + 1); s_tlast = (k + 1 == 4); s_tkeep = (k + 1 == 4) ? 4'h3 : 4'hF;
      end else begin
        s_tvalid = 1'b0; s_tlast = 1'b0;
      end
      @(negedge clk);
      exp_keep = (k == 4) ? 4'h3 : 4'hF;
      checks++; if (m_tvalid !== 16'h0020 || m_tdata !== 32'(k) || m_tlast !== (k == 4) || m_tkeep !== exp_keep) begin
        errors++; $display("FAIL single_beat%0d: got v=%h d=%h k=%h l=%b expected 0020/%h/%h/%b",
                           k, m_tvalid, m_tdata, m_tkeep, m_tlast, 32'(k), exp_keep, (k == 4)); end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (m_tvalid !== 16'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_drain: got valid=%h busy=%b expected 0000/0", m_tvalid, busy); end
  endtask

  task automatic test_backpressure();
    int unsigned sent, got, cyc;
    logic s_hs, stalled;
    logic [31:0] held;
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
    @(posedge clk); #1;
    m_tready = 16'hFFF7; sel = 4'd3; s_tvalid = 1'b1; s_tdata = 32'hA0; s_tkeep = 4'hF; s_tlast = 1'b0;
    while (got < 8 && cyc < 100) begin
      @(negedge clk); cyc++;
      checks++; if ((m_tvalid & ~16'h0008) !== 16'h0) begin
        errors++; $display("FAIL bp_other_valid: got %h expected only bit 3", m_tvalid); end
      if (sent - got == 2) begin
        checks++; if (s_tready !== 1'b0) begin
          errors++; $display("FAIL bp_ready_skid_full: got %b expected 0", s_tready); end
      end
      if (stalled) begin
        checks++; if (m_tvalid[3] !== 1'b1 || m_tdata !== held) begin
          errors++; $display("FAIL bp_stable: got v=%b d=%h expected 1/%h", m_tvalid[3], m_tdata, held); end
      end
      s_hs = s_tvalid && s_tready;
      if (m_tvalid[3] && m_tready[3]) begin
        checks++; if (m_tdata !== 32'hA0 + got || m_tlast !== (got == 7)) begin
          errors++; $display("FAIL bp_beat%0d: got d=%h l=%b expected %h/%b", got, m_tdata, m_tlast, 32'hA0 + got, (got == 7)); end
        got++;
      end
      stalled = m_tvalid[3] && !m_tready[3];
      held = m_tdata;
      @(posedge clk); #1;
      if (s_hs) begin
        sent++;
        if (sent < 8) begin s_tdata = 32'hA0 + sent; s_tlast = (sent == 7); end
        else begin s_tvalid = 1'b0; s_tlast = 1'b0; end
      end
      m_tready[3] = ~m_tready[3];
    end
    checks++; if (got != 8 || sent != 8) begin
      errors++; $display("FAIL bp_count: got sent=%0d delivered=%0d expected 8/8", sent, got); end
  endtask

  task automatic test_port_switch();
    logic [31:0] pd [5] = '{32'h11, 32'h12, 32'h13, 32'h21, 32'h22};
    int unsigned pp [5] = '{2, 2, 2, 9, 9};
    logic        pl [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0]  ps [5] = '{4'd2, 4'd4, 4'd4, 4'd9, 4'd9};
    int unsigned sent, got, cyc;
    logic s_hs, a_done;
    sent = 0; got = 0; cyc = 0;
    @(posedge clk); #1;
    m_tready = 16'hFFFB; sel = ps[0]; s_tvalid = 1'b1; s_tdata = pd[0]; s_tlast = pl[0]; s_tkeep = 4'hF;
    while (got < 5 && cyc < 100) begin
      @(negedge clk); cyc++;
      a_done = (got >= 3);
      checks++; if ((m_tvalid & ~(a_done ? 16'h0200 : 16'h0004)) !== 16'h0) begin
        errors++; $display("FAIL ps_valid_mask: got %h expected only bit %0d", m_tvalid, a_done ? 9 : 2); end
      if (!a_done && sent >= 1) begin
        checks++; if (cur_port !== 4'd2) begin
          errors++; $display("FAIL ps_cur_port: got %0d expected 2", cur_port); end
      end
      if (!a_done && sent >= 3) begin
        checks++; if (s_tready !== 1'b0) begin
          errors++; $display("FAIL ps_b_waits: got ready=%b expected 0", s_tready); end
      end
      s_hs = s_tvalid && s_tready;
      if (|(m_tvalid & m_tready)) begin
        checks++; if (m_tvalid !== (16'h0001 << pp[got]) || m_tdata !== pd[got] || m_tlast !== pl[got]) begin
          errors++; $display("FAIL ps_beat%0d: got v=%h d=%h l=%b expected %h/%h/%b",
                             got, m_tvalid, m_tdata, m_tlast, 16'h0001 << pp[got], pd[got], pl[got]); end
        got++;
      end
      @(posedge clk); #1;
      if (s_hs) begin
        sent++;
        if (sent < 5) begin sel = ps[sent]; s_tdata = pd[sent]; s_tlast = pl[sent]; end
        else begin s_tvalid = 1'b0; s_tlast = 1'b0; end
      end
      if (cyc == 5) m_tready = '1;
    end
    checks++; if (got != 5) begin
      errors++; $display("FAIL ps_count: got %0d beats expected 5", got); end
  endtask

  task automatic test_drop();
    @(posedge clk); #1;
    b_m_tready = '1; b_sel = 4'd14; b_s_tvalid = 1'b1; b_s_tdata = 32'hD0; b_s_tkeep = 4'hF; b_s_tlast = 1'b0;
    @(negedge clk);
    checks++; if (b_drop_cnt !== 2'd0 || b_s_tready !== 1'b0) begin
      errors++; $display("FAIL drop_start: got cnt=%0d ready=%b expected 0/0", b_drop_cnt, b_s_tready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (b_s_tready !== 1'b1 || b_m_tvalid !== 12'h0 || b_busy !== 1'b1) begin
      errors++; $display("FAIL drop_enter: got ready=%b valid=%h busy=%b expected 1/000/1", b_s_tready, b_m_tvalid, b_busy); end
    for (int unsigned k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k < 3) begin b_s_tdata = 32'hD0 + k; b_s_tlast = (k == 2); end
      else begin b_s_tvalid = 1'b0; b_s_tlast = 1'b0; end
      @(negedge clk);
      checks++; if (b_m_tvalid !== 12'h0 || b_drop_cnt !== ((k == 3) ? 2'd1 : 2'd0)) begin
        errors++; $display("FAIL drop_beat%0d: got valid=%h cnt=%0d expected 000/%0d", k, b_m_tvalid, b_drop_cnt, (k == 3) ? 1 : 0); end
      if (k < 3) begin
        checks++; if (b_s_tready !== 1'b1) begin
          errors++; $display("FAIL drop_ready%0d: got %b expected 1", k, b_s_tready); end
      end
    end
    checks++; if (b_busy !== 1'b0) begin
      errors++; $display("FAIL drop_idle: got busy=%b expected 0", b_busy); end
    @(posedge clk); #1;
    b_sel = 4'd0; b_s_tvalid = 1'b1; b_s_tdata = 32'h55; b_s_tlast = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b_s_tvalid = 1'b0; b_s_tlast = 1'b0;
    @(negedge clk);
    checks++; if (b_m_tvalid !== 12'h001 || b_m_tdata !== 32'h55 || b_m_tlast !== 1'b1) begin
      errors++; $display("FAIL drop_next_route: got v=%h d=%h l=%b expected 001/55/1", b_m_tvalid, b_m_tdata, b_m_tlast); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (b_m_tvalid !== 12'h0 || b_busy !== 1'b0 || b_drop_cnt !== 2'd1) begin
      errors++; $display("FAIL drop_next_drain: got v=%h busy=%b cnt=%0d expected 000/0/1", b_m_tvalid, b_busy, b_drop_cnt); end
  endtask

  task automatic test_saturation();
    int unsigned cyc, exp_cnt;
    logic hs;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    b_m_tready = '1;
    for (int unsigned p = 1; p <= 5; p++) begin
      b_sel = 4'd13; b_s_tvalid = 1'b1; b_s_tlast = 1'b1; b_s_tdata = 32'hE0 + p;
      hs = 1'b0; cyc = 0;
      while (!hs && cyc < 10) begin
        @(negedge clk); cyc++;
        hs = b_s_tvalid && b_s_tready;
        @(posedge clk); #1;
      end
      b_s_tvalid = 1'b0; b_s_tlast = 1'b0;
      @(negedge clk);
      exp_cnt = (p < 3) ? p : 3;
      checks++; if (!hs || b_drop_cnt !== 2'(exp_cnt)) begin
        errors++; $display("FAIL sat_pkt%0d: got hs=%b cnt=%0d expected 1/%0d", p, hs, b_drop_cnt, exp_cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int unsigned sent, got, cyc;
    logic s_hs;
    @(posedge clk); #1;
    m_tready = '1; sel = 4'd7; s_tvalid = 1'b1; s_tdata = 32'h61; s_tkeep = 4'hF; s_tlast = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_tdata = 32'h62;
    @(negedge clk);
    checks++; if (m_tvalid !== 16'h0080 || busy !== 1'b1 || b_drop_cnt !== 2'd3) begin
      errors++; $display("FAIL rm_pre: got v=%h busy=%b bcnt=%0d expected 0080/1/3", m_tvalid, busy, b_drop_cnt); end
    #2 rst = 1'b0;
    #1;
    checks++; if (s_tready !== 1'b0 || m_tvalid !== 16'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL rm_ctrl: got r=%b v=%h busy=%b expected 0/0000/0", s_tready, m_tvalid, busy); end
    checks++; if (m_tdata !== 32'h0 || m_tlast !== 1'b0 || cur_port !== 4'd0 || drop_cnt !== 16'd0 || b_drop_cnt !== 2'd0) begin
      errors++; $display("FAIL rm_state: got d=%h l=%b port=%0d cnt=%0d bcnt=%0d expected 0/0/0/0/0",
                         m_tdata, m_tlast, cur_port, drop_cnt, b_drop_cnt); end
    s_tvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    sel = 4'd7; s_tvalid = 1'b1; s_tdata = 32'h71; s_tlast = 1'b0;
    sent = 0; got = 0; cyc = 0;
    while (got < 2 && cyc < 50) begin
      @(negedge clk); cyc++;
      s_hs = s_tvalid && s_tready;
      if (|(m_tvalid & m_tready)) begin
        checks++; if (m_tvalid !== 16'h0080 || m_tdata !== ((got == 0) ? 32'h71 : 32'h72) || m_tlast !== (got == 1)) begin
          errors++; $display("FAIL rm_beat%0d: got v=%h d=%h l=%b expected 0080/%h/%b",
                             got, m_tvalid, m_tdata, m_tlast, (got == 0) ? 32'h71 : 32'h72, (got == 1)); end
        got++;
      end
      @(posedge clk); #1;
      if (s_hs) begin
        sent++;
        if (sent == 1) begin s_tdata = 32'h72; s_tlast = 1'b1; end
        else begin s_tvalid = 1'b0; s_tlast = 1'b0; end
      end
    end
    checks++; if (got != 2) begin
      errors++; $display("FAIL rm_count: got %0d beats expected 2", got); end
  endtask

  initial begin
    s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0; m_tready = '0; sel = '0;
    b_s_tdata = '0; b_s_tkeep = '0; b_s_tlast = 1'b0; b_s_tvalid = 1'b0; b_m_tready = '0; b_sel = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_port_switch();
    test_drop();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
